// File: rtl/uctl_mem_pkg.sv
// Shared constants and helpers for the arbitrated endpoint buffer memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uctl_mem_pkg;

    // Port identifiers, also the encoding of the arbiter's last-grant state.
    localparam logic UCTL_MEM_PORT_A = 1'b0;
    localparam logic UCTL_MEM_PORT_B = 1'b1;

    // Byte lanes per memory word.
    function automatic int uctl_mem_nb(input int data_size);
        return data_size / 8;
    endfunction

    // Even parity bit for one byte: byte plus parity has an even number of ones.
    function automatic logic uctl_mem_par8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uctl_mem_rr_arb.sv
// Two-requester round-robin arbiter producing a one-hot grant (bit0 = A, bit1 = B).
// Latency: grant is combinational in the request cycle; last-grant state updates at the edge.
// Backpressure: a losing requester holds its request and wins the next cycle.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_req_a/b      access requests
//   o_gnt          one-hot grant, all zero while i_rst is high
module uctl_mem_rr_arb
    import uctl_mem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_a,
    input  logic       i_req_b,
    output logic [1:0] o_gnt
);

    logic r_last_gnt;

    // On a conflict the port that did not win last time is granted.
    always_comb begin
        o_gnt = 2'b00;
        if (!i_rst) begin
            if (i_req_a && (!i_req_b || r_last_gnt == UCTL_MEM_PORT_B)) begin
                o_gnt = 2'b01;
            end else if (i_req_b) begin
                o_gnt = 2'b10;
            end
        end
    end

    // Reset to B so that A wins the first conflict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_gnt <= UCTL_MEM_PORT_B;
        end else if (o_gnt[0]) begin
            r_last_gnt <= UCTL_MEM_PORT_A;
        end else if (o_gnt[1]) begin
            r_last_gnt <= UCTL_MEM_PORT_B;
        end
    end

endmodule

// File: rtl/uctl_arb_memory.sv
// Arbitrated byte-writable single-ported buffer memory shared by DMA (port A) and USB engine (port B).
// Latency: ack combinational in the access cycle; read data and rvalid registered one cycle later.
// Backpressure: requester holds req and payload until ack; a conflict costs at most one cycle.
//
// Ports (x = a, b): x_req/x_wr/x_addr/x_be/x_dataIn request side, x_ack grant,
//   x_rvalid/x_dataOut/x_parErr read return. coreClk/coreRst: clock and synchronous
//   active-high reset. Optional macro UCTL_MEM_PARITY_EN adds per-lane even parity
//   storage and read-side checking; without it x_parErr is tied low.
module uctl_arb_memory
    import uctl_mem_pkg::*;
#(
    parameter int MEM_ADDR_SIZE = 13,
    parameter int MEM_DATA_SIZE = 32
) (
    input  logic                         coreClk,
    input  logic                         coreRst,
    input  logic                         a_req,
    input  logic                         a_wr,
    input  logic [MEM_ADDR_SIZE-1:0]     a_addr,
    input  logic [MEM_DATA_SIZE/8-1:0]   a_be,
    input  logic [MEM_DATA_SIZE-1:0]     a_dataIn,
    output logic                         a_ack,
    output logic                         a_rvalid,
    output logic [MEM_DATA_SIZE-1:0]     a_dataOut,
    output logic                         a_parErr,
    input  logic                         b_req,
    input  logic                         b_wr,
    input  logic [MEM_ADDR_SIZE-1:0]     b_addr,
    input  logic [MEM_DATA_SIZE/8-1:0]   b_be,
    input  logic [MEM_DATA_SIZE-1:0]     b_dataIn,
    output logic                         b_ack,
    output logic                         b_rvalid,
    output logic [MEM_DATA_SIZE-1:0]     b_dataOut,
    output logic                         b_parErr
);

    localparam int NB    = uctl_mem_nb(MEM_DATA_SIZE);
    localparam int DEPTH = 2 ** MEM_ADDR_SIZE;

    logic [1:0]               w_gnt;
    logic                     w_acc;
    logic                     w_wr;
    logic [MEM_ADDR_SIZE-1:0] w_addr;
    logic [NB-1:0]            w_be;
    logic [MEM_DATA_SIZE-1:0] w_din;
    logic [MEM_DATA_SIZE-1:0] w_rd_word;
    logic                     w_rd_perr;
    logic                     w_a_rd;
    logic                     w_b_rd;

    logic [MEM_DATA_SIZE-1:0] r_mem [DEPTH];
    logic                     r_a_rvalid;
    logic                     r_b_rvalid;
    logic                     r_a_perr;
    logic                     r_b_perr;
    logic [MEM_DATA_SIZE-1:0] r_a_dout;
    logic [MEM_DATA_SIZE-1:0] r_b_dout;

    uctl_mem_rr_arb u_arb (
        .i_clk   (coreClk),
        .i_rst   (coreRst),
        .i_req_a (a_req),
        .i_req_b (b_req),
        .o_gnt   (w_gnt)
    );

    assign a_ack = w_gnt[0];
    assign b_ack = w_gnt[1];

    // Single shared access path steered by the one-hot grant.
    assign w_acc  = |w_gnt;
    assign w_wr   = w_gnt[1] ? b_wr     : a_wr;
    assign w_addr = w_gnt[1] ? b_addr   : a_addr;
    assign w_be   = w_gnt[1] ? b_be     : a_be;
    assign w_din  = w_gnt[1] ? b_dataIn : a_dataIn;

    assign w_a_rd = a_ack && !a_wr;
    assign w_b_rd = b_ack && !b_wr;

    // Array contents are deliberately not reset.
    always_ff @(posedge coreClk) begin
        if (w_acc && w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr][i*8 +: 8] <= w_din[i*8 +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_addr];

`ifdef UCTL_MEM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];

    always_ff @(posedge coreClk) begin
        if (w_acc && w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    r_par[w_addr][i] <= uctl_mem_par8(w_din[i*8 +: 8]);
                end
            end
        end
    end

    always_comb begin
        w_rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            w_rd_perr = w_rd_perr |
                        (r_par[w_addr][i] != uctl_mem_par8(w_rd_word[i*8 +: 8]));
        end
    end
`else
    assign w_rd_perr = 1'b0;
`endif

    // Each port's return registers only move on that port's own read.
    always_ff @(posedge coreClk) begin
        if (coreRst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_perr   <= 1'b0;
            r_b_perr   <= 1'b0;
            r_a_dout   <= '0;
            r_b_dout   <= '0;
        end else begin
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
            r_a_perr   <= w_a_rd && w_rd_perr;
            r_b_perr   <= w_b_rd && w_rd_perr;
            if (w_a_rd) begin
                r_a_dout <= w_rd_word;
            end
            if (w_b_rd) begin
                r_b_dout <= w_rd_word;
            end
        end
    end

    // A reset arriving the cycle after a read ack discards that read immediately.
    assign a_rvalid  = r_a_rvalid & ~coreRst;
    assign b_rvalid  = r_b_rvalid & ~coreRst;
    assign a_parErr  = r_a_perr & ~coreRst;
    assign b_parErr  = r_b_perr & ~coreRst;
    assign a_dataOut = r_a_dout;
    assign b_dataOut = r_b_dout;

endmodule

// File: doc/uctl_arb_memory.md
# uctl_arb_memory

Arbitrated, byte-writable, parametrised endpoint buffer memory for the USB controller. Two requesters share one single-ported array: port A for the system/DMA side and port B for the USB protocol engine. Round-robin arbitration grants one access per clock. Reads return registered data one cycle after grant. The block replaces the fixed 8-bit, non-arbitrated buffer RAM and supports word widths of multiple bytes with per-byte write strobes.

## Interface
Parameters:
- MEM_ADDR_SIZE, 13, word-address width; depth = 2**MEM_ADDR_SIZE words
- MEM_DATA_SIZE, 32, word width in bits; must be a multiple of 8; byte lanes NB = MEM_DATA_SIZE/8

Ports (x = a or b, one identical set per port):
- coreClk  in  1  core clock; all logic on its rising edge
- coreRst  in  1  synchronous, active-high reset
- x_req  in  1  access request; held with x_wr/x_addr/x_be/x_dataIn stable until x_ack
- x_wr  in  1  1 = write, 0 = read
- x_addr  in  MEM_ADDR_SIZE  word address
- x_be  in  NB  byte-lane write enables; ignored on reads
- x_dataIn  in  MEM_DATA_SIZE  write data
- x_ack  out  1  grant; combinational, asserted in the cycle the access is performed
- x_rvalid  out  1  registered read-data strobe, one cycle after a read ack
- x_dataOut  out  MEM_DATA_SIZE  read data; holds its value until the next read on this port
- x_parErr  out  1  parity error qualifier, valid with x_rvalid

## Operation
- Arbiter state: lastGrant (1 bit, A=0/B=1). Reset value B, so A wins the first conflict.
- Only A requests: ack A. Only B requests: ack B. Both request: ack the port not equal to lastGrant. lastGrant updates on every ack.
- At most one ack per cycle. A losing port keeps req high and is served next cycle. Worst-case wait is 1 cycle.
- Write on ack: for each lane i with x_be[i]=1, the array byte i at x_addr ← x_dataIn byte i. Other lanes are unchanged. x_be = 0 is a legal no-op write that still acks.
- Read on ack: array word at x_addr is captured into x_dataOut at the clock edge; x_rvalid = 1 for the following cycle.
- Read of an address written in a previous cycle returns the new data.
- Address width is exact. No wrap or out-of-range case exists.
- A port's dataOut/rvalid are never disturbed by the other port's accesses.

## Timing
- Cycle N: x_req=1 and granted → x_ack=1 (same cycle), array access at the edge ending N.
- Cycle N+1: for a read, x_rvalid=1 and x_dataOut valid. A port may issue back-to-back reads; one read per cycle when uncontended.
- Reset values: x_ack=0 (req ignored while coreRst=1), x_rvalid=0, x_dataOut=0, x_parErr=0, lastGrant=B. Array contents are not reset.
- coreRst asserted in the cycle after a read ack: x_rvalid is forced to 0 and that read is discarded.

## Configuration
- UCTL_MEM_PARITY_EN defined: the array stores one even-parity bit per byte lane, written per lane with the data byte. On read, x_parErr = OR of per-lane parity mismatches, registered with x_rvalid (0 when x_rvalid=0).
- Undefined: no parity storage; x_parErr is tied 0. Ports are identical in both builds.

## Structure
- Package uctl_mem_pkg: port-id constants (UCTL_MEM_PORT_A=0, UCTL_MEM_PORT_B=1), byte-lane count derivation, per-byte parity function.
- Sub-module uctl_mem_rr_arb: two-requester round-robin arbiter owning lastGrant and producing the one-hot grant.
- Array, write-lane logic and read registers stay in uctl_arb_memory.

## Test plan
- Post-reset: assert coreRst 2 cycles with a_req=b_req=1 → no acks, all outputs 0. First cycle after release: a_ack=1, b_ack=0.
- Write A addr 0x010 data 0xAABBCCDD be=4'hF, then read B addr 0x010 → b_rvalid one cycle after b_ack, b_dataOut=0xAABBCCDD.
- Partial write: A writes 0x11223344 be=4'b0101 over 0xAABBCCDD → subsequent read returns 0xAA22CC44.
- Both ports hold reads for 6 cycles → acks alternate A,B,A,B,A,B; each port gets 3 rvalid pulses with correct data.
- Read acked, then coreRst asserted next cycle → x_rvalid stays 0.
- With UCTL_MEM_PARITY_EN: force one stored parity bit flipped at addr 0x020, read it → a_parErr=1 with a_rvalid. A clean address reads with a_parErr=0.
